regfile_wr_sched: RTL

REGFILE_WR_SCHED -- requirements
Module: regfile_wr_sched

---
 rtl/regfile_wr_sched_if.sv | 63 ++++++
 rtl/regfile_wr_sched.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/regfile_wr_sched_if.sv
// Writeback, issue and decode-side signal bundle for regfile_wr_sched.
// The slave modport is the scheduler's view; the master modport is the
// view of whatever drives the requesters and consumes the write port.
interface regfile_wr_sched_if #(
  parameter int CW = 16
);
  // Pipeline writeback (never back-pressured)
  logic          wb_valid;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  // Multiply/divide writeback handshake
  logic          md_valid;
  logic [4:0]    md_addr;
  logic [31:0]   md_data;
  logic          md_ready;
  // Load-return writeback handshake
  logic          ld_valid;
  logic [4:0]    ld_addr;
  logic [31:0]   ld_data;
  logic          ld_ready;
  // Long-latency issue and scoreboard query
  logic          issue_en;
  logic [4:0]    issue_addr;
  logic          issue_busy;
  // Decode-stage source operands
  logic [4:0]    raddr_A;
  logic [4:0]    raddr_B;
  logic          stall;
  // Registered register-file write port
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  // Blocked-requester cycle counter
  logic [CW-1:0] stall_cnt;

  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  md_valid, md_addr, md_data,
    output md_ready,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    input  issue_en, issue_addr,
    output issue_busy,
    input  raddr_A, raddr_B,
    output stall,
    output rf_we, rf_waddr, rf_wdata,
    output stall_cnt
  );

  modport master (
    output wb_valid, wb_addr, wb_data,
    output md_valid, md_addr, md_data,
    input  md_ready,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    output issue_en, issue_addr,
    input  issue_busy,
    output raddr_A, raddr_B,
    input  stall,
    input  rf_we, rf_waddr, rf_wdata,
    input  stall_cnt
  );
endinterface

// File: rtl/regfile_wr_sched.sv
// Register-file write scheduler with pending-register scoreboard.
// Pipeline writeback always wins the single write port; multiply/divide and
// load returns share the remaining slot round-robin. A scoreboard of pending
// bits tracks long-latency destinations and stalls decode on a hazard.
module regfile_wr_sched #(
  parameter int NREG = 16,
  parameter int CW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wr_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_MD,
    GNT_LD
  } grant_e;

  typedef enum logic {
    LAST_MD,
    LAST_LD
  } last_e;

  // True when the address names an implemented, writable register.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREG);
  endfunction

  // Pending bit of an address; register 0 and unimplemented addresses read 0.
  function automatic logic pend_at(input logic [NREG-1:0] p, input logic [4:0] a);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (int'(a) == i) hit = p[i];
    end
    return hit;
  endfunction

  // State
  last_e          last_q,      last_d;
  logic [NREG-1:0] pending_q,  pending_d;
  logic           rf_we_q,     rf_we_d;
  logic [4:0]     rf_waddr_q,  rf_waddr_d;
  logic [31:0]    rf_wdata_q,  rf_wdata_d;
  logic [CW-1:0]  stall_cnt_q, stall_cnt_d;

  // Combinational handshake terms
  grant_e grant;
  logic   md_ready_w;
  logic   ld_ready_w;
  logic   md_acc;
  logic   ld_acc;
  logic   blocked;

  // Round-robin pick between md and ld; wb is applied on top via ready.
  always_comb begin
    // NOTE: assign a default first on every path so no latch is inferred.
    grant = GNT_NONE;
    if (bus.md_valid && bus.ld_valid) begin
      grant = (last_q == LAST_LD) ? GNT_MD : GNT_LD;
    end else if (bus.md_valid) begin
      grant = GNT_MD;
    end else if (bus.ld_valid) begin
      grant = GNT_LD;
    end
  end

  assign md_ready_w = !rst && !bus.wb_valid && bus.md_valid && (grant == GNT_MD);
  assign ld_ready_w = !rst && !bus.wb_valid && bus.ld_valid && (grant == GNT_LD);
  assign md_acc     = bus.md_valid && md_ready_w;
  assign ld_acc     = bus.ld_valid && ld_ready_w;
  assign blocked    = (bus.md_valid && !md_ready_w) || (bus.ld_valid && !ld_ready_w);

  // Next-state: write-port mux, grant pointer, scoreboard and stall counter.
  always_comb begin
    last_d      = last_q;
    pending_d   = pending_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    stall_cnt_d = stall_cnt_q;

    if (bus.wb_valid) begin
      rf_we_d    = addr_ok(bus.wb_addr);
      rf_waddr_d = bus.wb_addr;
      rf_wdata_d = bus.wb_data;
    end else if (md_acc) begin
      rf_we_d    = addr_ok(bus.md_addr);
      rf_waddr_d = bus.md_addr;
      rf_wdata_d = bus.md_data;
      last_d     = LAST_MD;
    end else if (ld_acc) begin
      rf_we_d    = addr_ok(bus.ld_addr);
      rf_waddr_d = bus.ld_addr;
      rf_wdata_d = bus.ld_data;
      last_d     = LAST_LD;
    end

    // Clears first, then the issue set, so a same-address set wins.
    for (int i = 1; i < NREG; i++) begin
      if (md_acc && (int'(bus.md_addr) == i))       pending_d[i] = 1'b0;
      if (ld_acc && (int'(bus.ld_addr) == i))       pending_d[i] = 1'b0;
      if (bus.issue_en && (int'(bus.issue_addr) == i)) pending_d[i] = 1'b1;
    end

    if (blocked && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= LAST_LD;
      // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset
      // like any other state; a dangling pending bit would stall forever.
      pending_q   <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      last_q      <= last_d;
      pending_q   <= pending_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.md_ready   = md_ready_w;
  assign bus.ld_ready   = ld_ready_w;
  assign bus.issue_busy = pend_at(pending_q, bus.issue_addr);
  assign bus.stall      = pend_at(pending_q, bus.raddr_A) | pend_at(pending_q, bus.raddr_B);
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule
